// File: rtl/n_input_gate_sweeper.sv
// n_input_gate_sweeper: run-time selectable N-input reduction gate with a
// registered output, plus an exhaustive sweep engine that walks all 2^N input
// patterns (one per clock) and counts how many of them evaluate to 1.
module n_input_gate_sweeper #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   mode,
    input  logic [N-1:0] ext_in,
    input  logic         start,
    output logic         y,
    output logic [N-1:0] pattern,
    output logic         busy,
    output logic         done,
    output logic [N:0]   ones_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [N-1:0] PAT_LAST = '1;

    state_t     state;
    state_t     state_next;
    logic [2:0] mode_q;
    logic       sweep_bit;

    // Reduction of v under gate mode m; modes 6 and 7 are reserved and yield 0.
    function automatic logic gate_reduce(input logic [N-1:0] v, input logic [2:0] m);
        logic r;
        case (m)
            3'd0:    r = &v;
            3'd1:    r = |v;
            3'd2:    r = ^v;
            3'd3:    r = ~&v;
            3'd4:    r = ~|v;
            3'd5:    r = ~^v;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign sweep_bit = gate_reduce(pattern, mode_q);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is only honoured in IDLE; a sweep ends after the
    // all-ones pattern has been evaluated, and DONE always returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SWEEP;
            SWEEP:   if (pattern == PAT_LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gate output, sweep pattern, latched mode and ones counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y        <= 1'b0;
            pattern  <= '0;
            ones_cnt <= '0;
            mode_q   <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    y <= gate_reduce(ext_in, mode);
                    if (start) begin
                        mode_q   <= mode;
                        pattern  <= '0;
                        ones_cnt <= '0;
                    end
                end
                SWEEP: begin
                    y        <= sweep_bit;
                    ones_cnt <= ones_cnt + {{N{1'b0}}, sweep_bit};
                    // Natural N-bit wrap returns pattern to 0 after the last one.
                    pattern  <= pattern + 1'b1;
                end
                default: begin
                    // DONE: everything holds for the single pulse cycle.
                end
            endcase
        end
    end

    // Status flags registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next == SWEEP);
            done <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_n_input_gate_sweeper.sv
// Testbench for n_input_gate_sweeper: N=4 instance checked cycle by cycle
// against a behavioural model, with N=1 and N=8 instances for width regressions.
module tb_n_input_gate_sweeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] mode = 3'd0;

    logic [3:0] ext_in = 4'd0;
    logic       start = 1'b0;
    logic       y;
    logic [3:0] pattern;
    logic       busy;
    logic       done;
    logic [4:0] ones_cnt;

    logic [0:0] ext_in1 = 1'b0;
    logic       start1 = 1'b0;
    logic       y1;
    logic [0:0] pattern1;
    logic       busy1;
    logic       done1;
    logic [1:0] ones_cnt1;

    logic [7:0] ext_in8 = 8'd0;
    logic       start8 = 1'b0;
    logic       y8;
    logic [7:0] pattern8;
    logic       busy8;
    logic       done8;
    logic [8:0] ones_cnt8;

    int vectors = 0;
    int miscompares = 0;

    n_input_gate_sweeper #(.N(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .ext_in(ext_in), .start(start),
        .y(y), .pattern(pattern), .busy(busy), .done(done), .ones_cnt(ones_cnt)
    );

    n_input_gate_sweeper #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .ext_in(ext_in1), .start(start1),
        .y(y1), .pattern(pattern1), .busy(busy1), .done(done1), .ones_cnt(ones_cnt1)
    );

    n_input_gate_sweeper #(.N(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .ext_in(ext_in8), .start(start8),
        .y(y8), .pattern(pattern8), .busy(busy8), .done(done8), .ones_cnt(ones_cnt8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Gate truth from the textual definition of each mode, using counts of ones.
    function automatic int model_f(input int v, input int n, input int m);
        int full;
        int ones;
        full = (1 << n) - 1;
        ones = $countones(v);
        case (m)
            0: return (v == full) ? 1 : 0;
            1: return (v != 0) ? 1 : 0;
            2: return ones % 2;
            3: return (v != full) ? 1 : 0;
            4: return (v == 0) ? 1 : 0;
            5: return 1 - (ones % 2);
            default: return 0;
        endcase
    endfunction

    function automatic int model_count(input int n, input int m);
        int c = 0;
        for (int v = 0; v < (1 << n); v++) c += model_f(v, n, m);
        return c;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the first IDLE cycle
    // after DONE so that a following call exercises back-to-back starting.
    task automatic run_sweep(input int m, input bit disturb);
        int cycles;
        int running;
        mode  = 3'(m);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cycles  = 0;
        running = 0;
        while (busy && cycles < 40) begin
            check("pattern", int'(pattern), cycles);
            check("ones_run", int'(ones_cnt), running);
            check("no_done_in_sweep", int'(done), 0);
            if (cycles > 0) check("y_sweep", int'(y), model_f(cycles - 1, 4, m));
            running += model_f(cycles, 4, m);
            if (disturb) begin
                start  = 1'($urandom);
                mode   = 3'($urandom_range(0, 7));
                ext_in = 4'($urandom);
            end
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        mode  = 3'(m);
        check("busy_len", cycles, 16);
        check("done_pulse", int'(done), 1);
        check("busy_in_done", int'(busy), 0);
        check("ones_final", int'(ones_cnt), model_count(4, m));
        check("y_done", int'(y), model_f(15, 4, m));
        check("pattern_wrap", int'(pattern), 0);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("busy_after", int'(busy), 0);
        check("ones_hold", int'(ones_cnt), model_count(4, m));
    endtask

    initial begin
        int cnt;
        int m;
        logic [3:0] v;

        // Reset state
        #2;
        check("rst_y", int'(y), 0);
        check("rst_pattern", int'(pattern), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ones", int'(ones_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle gate: directed then random
        mode = 3'd0; ext_in = 4'b1111;
        @(negedge clk);
        check("idle_and_1111", int'(y), 1);
        ext_in = 4'b1110;
        @(negedge clk);
        check("idle_and_1110", int'(y), 0);
        for (int i = 0; i < 40; i++) begin
            v = 4'($urandom);
            m = int'($urandom_range(0, 7));
            ext_in = v;
            mode = 3'(m);
            @(negedge clk);
            check("idle_rand", int'(y), model_f(int'(v), 4, m));
            check("idle_pattern", int'(pattern), 0);
            check("idle_busy", int'(busy), 0);
        end

        // Sweeps over every mode, the last pair back to back
        for (int k = 0; k < 8; k++) run_sweep(k, 1'b0);
        run_sweep(2, 1'b0);

        // Disturbed AND sweep: start/mode/ext_in activity must be ignored
        run_sweep(0, 1'b1);

        // Random-mode sweeps
        for (int i = 0; i < 3; i++) run_sweep(int'($urandom_range(0, 7)), 1'b1);

        // Asynchronous reset mid-sweep
        mode = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_y", int'(y), 0);
        check("arst_pattern", int'(pattern), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_done", int'(done), 0);
        check("arst_ones", int'(ones_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_ones", int'(ones_cnt), 0);
        run_sweep(0, 1'b0);

        // N=1 regression
        mode = 3'd2; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cnt = 0;
        while (busy1 && cnt < 20) begin cnt++; @(negedge clk); end
        check("n1_busy_len", cnt, 2);
        check("n1_done", int'(done1), 1);
        check("n1_ones", int'(ones_cnt1), model_count(1, 2));

        // N=8 regression
        @(negedge clk);
        mode = 3'd2; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cnt = 0;
        while (busy8 && cnt < 300) begin
            if (cnt > 0) check("n8_y", int'(y8), model_f(cnt - 1, 8, 2));
            cnt++;
            @(negedge clk);
        end
        check("n8_busy_len", cnt, 256);
        check("n8_done", int'(done8), 1);
        check("n8_ones", int'(ones_cnt8), model_count(8, 2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
